// File: rtl/divider_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings.
// Encodings are kept identical to the legacy include so traces line up.
package divider_iter_pkg;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_BUSY = 2'd1;
    localparam logic [1:0] DIV_FIX  = 2'd2;

endpackage

// File: rtl/divider_iter_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when non-negative and shift the quotient bit in.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] dq,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] dq_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // acc MSB is kept as bit WIDTH so divisors above 2^(WIDTH-1) still divide correctly
        shifted  = {acc, dq[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        acc_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dq_next  = {dq[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/divider_iter.sv
// Iterative restoring divider, signed or unsigned per operation, with quotient,
// remainder, divide-by-zero and overflow reporting and a fixed WIDTH+2 cycle latency.
module divider_iter
    import divider_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             in_ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc, dq, dvs, dividend_raw;
    logic [WIDTH-1:0] acc_next, dq_next;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             neg_q, neg_r, zero_f, ovf_f;

    assign in_ready = (state == DIV_IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .dq       (dq),
        .dvs      (dvs),
        .acc_next (acc_next),
        .dq_next  (dq_next)
    );

    always_comb begin
        dividend_mag = (is_signed & dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_mag  = (is_signed & divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // Special cases override the iterated result; the iteration still runs so latency is fixed
    always_comb begin
        q_fix = neg_q ? -dq  : dq;
        r_fix = neg_r ? -acc : acc;
        if (zero_f) begin
            q_fix = '1;
            r_fix = dividend_raw;
        end else if (ovf_f) begin
            q_fix = MIN_VAL;
            r_fix = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= DIV_IDLE;
            count        <= '0;
            acc          <= '0;
            dq           <= '0;
            dvs          <= '0;
            dividend_raw <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            zero_f       <= 1'b0;
            ovf_f        <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        acc          <= '0;
                        dq           <= dividend_mag;
                        dvs          <= divisor_mag;
                        dividend_raw <= dividend;
                        neg_q        <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r        <= is_signed & dividend[WIDTH-1];
                        zero_f       <= (divisor == '0);
                        ovf_f        <= is_signed & (dividend == MIN_VAL) & (divisor == '1);
                        count        <= '0;
                        div_by_zero  <= 1'b0;
                        overflow     <= 1'b0;
                        state        <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    acc   <= acc_next;
                    dq    <= dq_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1))
                        state <= DIV_FIX;
                end
                DIV_FIX: begin
                    quotient    <= q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= zero_f;
                    overflow    <= ovf_f;
                    done        <= 1'b1;
                    state       <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: directed corner cases plus random operands
// compared against an arithmetic reference model, on WIDTH=32 and WIDTH=8 instances.
module tb_divider_iter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start32 = 1'b0;
    logic        start8 = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;

    logic        rdy32, done32, dz32, ov32;
    logic [31:0] q32, r32;
    logic        rdy8, done8, dz8, ov8;
    logic [7:0]  q8, r8;

    int n_checks = 0;
    int n_fails  = 0;
    bit sel8 = 1'b0;

    logic        o_rdy, o_done, o_dz, o_ov;
    logic [31:0] o_q, o_r;

    always #5 clock = ~clock;

    divider_iter #(.WIDTH(32)) dut32 (
        .clock       (clock),
        .reset       (reset),
        .start       (start32),
        .is_signed   (is_signed),
        .dividend    (opa),
        .divisor     (opb),
        .in_ready    (rdy32),
        .done        (done32),
        .quotient    (q32),
        .remainder   (r32),
        .div_by_zero (dz32),
        .overflow    (ov32)
    );

    divider_iter #(.WIDTH(8)) dut8 (
        .clock       (clock),
        .reset       (reset),
        .start       (start8),
        .is_signed   (is_signed),
        .dividend    (opa[7:0]),
        .divisor     (opb[7:0]),
        .in_ready    (rdy8),
        .done        (done8),
        .quotient    (q8),
        .remainder   (r8),
        .div_by_zero (dz8),
        .overflow    (ov8)
    );

    always_comb begin
        o_rdy  = sel8 ? rdy8  : rdy32;
        o_done = sel8 ? done8 : done32;
        o_dz   = sel8 ? dz8   : dz32;
        o_ov   = sel8 ? ov8   : ov32;
        o_q    = sel8 ? {24'h0, q8} : q32;
        o_r    = sel8 ? {24'h0, r8} : r32;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain truncating division on sign-interpreted 64-bit integers
    function automatic void model(input int w, input bit sg, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r,
                                  output bit dz, output bit ov);
        logic [63:0] mask, minv;
        longint      sa, sb;
        mask = (64'h1 << w) - 64'h1;
        minv = 64'h1 << (w - 1);
        if (sg) begin
            sa = a[w-1] ? longint'(a | ~mask) : longint'(a);
            sb = b[w-1] ? longint'(b | ~mask) : longint'(b);
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        dz = (b == 64'h0);
        ov = sg && (a == minv) && (b == mask);
        if (dz) begin
            q = mask;
            r = a;
        end else if (ov) begin
            q = minv;
            r = 64'h0;
        end else begin
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or the bound expires)
    task automatic run_op(input bit w8, input bit sg, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        int          w;
        int          cyc;
        logic [31:0] am, bm;
        logic [63:0] eq, er;
        bit          edz, eov;
        w  = w8 ? 8 : 32;
        am = w8 ? {24'h0, a[7:0]} : a;
        bm = w8 ? {24'h0, b[7:0]} : b;
        model(w, sg, {32'h0, am}, {32'h0, bm}, eq, er, edz, eov);
        sel8 = w8;
        check_val("in_ready_idle", o_rdy, 1);
        is_signed = sg;
        opa = am;
        opb = bm;
        if (w8) start8 = 1'b1; else start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        start8 = 1'b0;
        is_signed = ~sg;
        opa = $urandom;
        opb = $urandom;
        cyc = 1;
        check_val("done_single_pulse", o_done, 0);
        check_val("in_ready_busy", o_rdy, 0);
        while (!o_done && cyc < 100) begin
            if (cyc == poke) begin
                if (w8) start8 = 1'b1; else start32 = 1'b1;
            end
            @(negedge clock);
            start32 = 1'b0;
            start8 = 1'b0;
            cyc++;
        end
        check_val("latency", cyc, w + 2);
        check_val("quotient", o_q, eq);
        check_val("remainder", o_r, er);
        check_val("div_by_zero", o_dz, edz);
        check_val("overflow", o_ov, eov);
    endtask

    initial begin
        int ndone;
        logic [31:0] a, b;
        bit sg;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        sel8 = 1'b0;
        check_val("rst_in_ready", o_rdy, 1);
        check_val("rst_done", o_done, 0);
        check_val("rst_quotient", o_q, 0);
        check_val("rst_remainder", o_r, 0);
        check_val("rst_div_by_zero", o_dz, 0);
        check_val("rst_overflow", o_ov, 0);

        // Directed 32-bit corners, issued back to back
        run_op(0, 1, 32'd100, 32'd7, 0);
        check_val("const_q_100_7", o_q, 14);
        check_val("const_r_100_7", o_r, 2);
        run_op(0, 1, 32'hFFFF_FF9C, 32'd7, 0);
        run_op(0, 1, 32'd100, 32'hFFFF_FFF9, 0);
        run_op(0, 0, 32'hFFFF_FFFF, 32'd2, 0);
        check_val("const_q_unsigned", o_q, 32'h7FFF_FFFF);
        run_op(0, 1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(0, 0, 32'd5, 32'd0, 0);
        run_op(0, 1, 32'd5, 32'd0, 0);
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_val("const_ovf_q", o_q, 32'h8000_0000);
        run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFD, 0);
        run_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op(0, 1, 32'd1000, 32'd33, 5);

        // Abort: accept 100/7, ignored start at cycle 5, reset at cycle 10
        sel8 = 1'b0;
        is_signed = 1'b1;
        opa = 32'd100;
        opb = 32'd7;
        start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        for (int k = 1; k < 10; k++) begin
            if (k == 5) start32 = 1'b1;
            @(negedge clock);
            start32 = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_val("abort_in_ready", o_rdy, 1);
        check_val("abort_done", o_done, 0);
        check_val("abort_quotient", o_q, 0);
        check_val("abort_remainder", o_r, 0);
        check_val("abort_div_by_zero", o_dz, 0);
        check_val("abort_overflow", o_ov, 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done32) ndone++;
        end
        check_val("abort_no_done", ndone, 0);

        // Directed 8-bit corners
        run_op(1, 0, 32'd200, 32'd13, 0);
        check_val("const_q_200_13", o_q, 15);
        check_val("const_r_200_13", o_r, 5);
        run_op(1, 1, 32'h80, 32'hFF, 0);
        run_op(1, 0, 32'h80, 32'hFF, 0);
        run_op(1, 1, 32'h9C, 32'h07, 0);
        run_op(1, 1, 32'h05, 32'h00, 0);

        // Random 32-bit operands with biased corner picks
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 9))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 15);
                4:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
                default: b = $urandom;
            endcase
            run_op(0, sg, a, b, 0);
        end

        // Random 8-bit operands
        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom_range(0, 1));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            run_op(1, sg, a, b, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
